// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle control sequencer for the 16-bit, 4-register datapath.
//   Owns the program counter and instruction register, fetches over a
//   req/ack port, and steps each instruction through
//   FETCH -> DECODE -> EXECUTE -> MEM -> WB, halting on opcode 15.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   imem_addr/req/ack/rdata   instruction fetch port (addr = pc)
//   instruction         latched instruction, feeds the decoder
//   dec_reg_write/mem_write/mem_to_reg   decoder strobes for the current instruction
//   branch_cond         ALU compare result, used in EXECUTE for opcodes 11/12
//   dmem_req/we/ack     data memory access port
//   reg_we              one-cycle register file write strobe
//   retire              one-cycle pulse when an instruction completes
//   halted              high in HALT
//   state               current state encoding (debug)
//   retired_cnt         wrapping count of retired instructions
module cpu_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [PC_W-1:0]  imem_addr,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    output logic [15:0]      instruction,
    input  logic             dec_reg_write,
    input  logic             dec_mem_write,
    input  logic             dec_mem_to_reg,
    input  logic             branch_cond,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             reg_we,
    output logic             retire,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd5
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [PC_W-1:0]  pc;
    logic [15:0]      ir;
    logic [CNT_W-1:0] cnt;

    logic [3:0]       opcode;
    logic             is_branch;
    logic             is_mem;
    logic             taken;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  branch_off;

    assign opcode     = ir[15:12];
    assign is_branch  = (opcode == 4'd11) || (opcode == 4'd12);
    assign is_mem     = (opcode == 4'd0) || (opcode == 4'd1);
    assign taken      = (cur_state == EXECUTE) && is_branch && branch_cond;
    assign pc_inc     = pc + PC_W'(1);
    // Sign-extend the 8-bit offset to PC_W; the sum wraps modulo 2^PC_W.
    assign branch_off = PC_W'(signed'(ir[7:0]));

    assign imem_addr   = pc;
    assign instruction = ir;
    assign retired_cnt = cnt;
    assign state       = cur_state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic
    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            FETCH: begin
                if (imem_ack) nxt_state = DECODE;
            end
            DECODE: begin
                if (opcode == 4'd15)      nxt_state = HALT;
                else if (opcode == 4'd14) nxt_state = FETCH;
                else                      nxt_state = EXECUTE;
            end
            EXECUTE: begin
                if (is_branch)          nxt_state = FETCH;
                else if (is_mem)        nxt_state = MEM;
                else if (dec_reg_write) nxt_state = WB;
                else                    nxt_state = FETCH;
            end
            MEM: begin
                if (dmem_ack) nxt_state = dec_mem_to_reg ? WB : FETCH;
            end
            WB:      nxt_state = FETCH;
            HALT:    nxt_state = HALT;
            default: nxt_state = FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        unique case (cur_state)
            FETCH:   imem_req = 1'b1;
            DECODE:  retire   = (opcode == 4'd15) || (opcode == 4'd14);
            EXECUTE: retire   = is_branch || (!is_mem && !dec_reg_write);
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                retire   = dmem_ack && !dec_mem_to_reg;
            end
            WB: begin
                reg_we = dec_reg_write;
                retire = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // Program counter, instruction register and retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc  <= '0;
            ir  <= '0;
            cnt <= '0;
        end else begin
            if ((cur_state == FETCH) && imem_ack) ir <= imem_rdata;
            if (retire) begin
                cnt <= cnt + CNT_W'(1);
                pc  <= taken ? (pc_inc + branch_off) : pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Randomized self-checking bench for cpu_sequencer. The bench plays the
//   instruction memory, data memory and instruction decoder; a per-instruction
//   reference model predicts cycle count, strobe counts, next pc and counter.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata;
    logic [15:0] instruction;
    logic        dec_reg_write, dec_mem_write, dec_mem_to_reg;
    logic        branch_cond = 1'b0;
    logic        dmem_req, dmem_we;
    logic        dmem_ack = 1'b0;
    logic        reg_we, retire, halted;
    logic [2:0]  state;
    logic [15:0] retired_cnt;

    int total = 0;
    int bad = 0;

    logic [15:0] imem [256];
    logic [7:0]  mpc;
    logic [15:0] mcnt;
    logic [15:0] mins;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];

    // Decoder model: opcode 0 load, 1 store, 11/12 branch, 13 compare-only,
    // 14 NOP, 15 HALT, everything else writes a register.
    logic [3:0] dop;
    assign dop            = instruction[15:12];
    assign dec_mem_to_reg = (dop == 4'd0);
    assign dec_mem_write  = (dop == 4'd1);
    assign dec_reg_write  = !(dop inside {4'd1, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15});

    cpu_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instruction(instruction),
        .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
        .dec_mem_to_reg(dec_mem_to_reg), .branch_cond(branch_cond),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .retire(retire), .halted(halted), .state(state),
        .retired_cnt(retired_cnt)
    );

    // Reset for one edge with a concurrent fetch ack (reset must win).
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        mpc = '0; mcnt = '0; mins = '0;
    endtask

    // Run one instruction at the model pc with fw fetch wait states,
    // mw data wait states and the given branch condition; check everything.
    task automatic run_instr(input int fw, input int mw, input bit bc);
        logic [15:0] ins;
        logic [3:0]  op;
        logic [7:0]  epc;
        int          ecyc, ereg, ereq, ewe, estate, t;
        int          cyc, nf, nm, nreg, nreq, nwe;
        bit          got, addr_bad, ins_bad;
        ins = imem[mpc]; op = ins[15:12];
        epc = mpc + 8'd1; estate = 0; ereg = 0; ereq = 0; ewe = 0;
        case (op)
            4'd15: begin ecyc = fw + 2; estate = 5; end
            4'd14: ecyc = fw + 2;
            4'd11, 4'd12: begin
                ecyc = fw + 3;
                if (bc) begin
                    t = int'(mpc) + 1 + int'($signed(ins[7:0]));
                    epc = 8'(t);
                end
            end
            4'd0:  begin ecyc = fw + mw + 5; ereg = 1; ereq = mw + 1; end
            4'd1:  begin ecyc = fw + mw + 4; ereq = mw + 1; ewe = mw + 1; end
            4'd13: ecyc = fw + 3;
            default: begin ecyc = fw + 4; ereg = 1; end
        endcase
        branch_cond = bc;
        cyc = 0; nf = 0; nm = 0; nreg = 0; nreq = 0; nwe = 0;
        got = 0; addr_bad = 0; ins_bad = 0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (imem_req) begin
                if (imem_addr !== mpc) addr_bad = 1;
                if (instruction !== mins) ins_bad = 1;
                imem_ack = (nf == fw); nf++;
            end else imem_ack = 1'($urandom_range(0, 1));
            if (dmem_req) begin
                dmem_ack = (nm == mw); nm++;
            end else dmem_ack = 1'($urandom_range(0, 1));
            #1;
            if (dmem_req) nreq++;
            if (dmem_we) nwe++;
            if (reg_we) nreg++;
            if (retire) got = 1;
        end
        @(posedge clk); #1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        mpc = epc; mcnt = mcnt + 16'd1; mins = ins;
        if (!got) begin bad++; $display("FAIL retire_timeout op=%0d cycles=%0d", op, cyc); end
        total++;
        if (cyc !== ecyc) begin bad++; $display("FAIL cycles op=%0d got=%0d exp=%0d", op, cyc, ecyc); end
        total++;
        if (nreg !== ereg) begin bad++; $display("FAIL reg_we_count op=%0d got=%0d exp=%0d", op, nreg, ereg); end
        total++;
        if (nreq !== ereq) begin bad++; $display("FAIL dmem_req_count op=%0d got=%0d exp=%0d", op, nreq, ereq); end
        total++;
        if (nwe !== ewe) begin bad++; $display("FAIL dmem_we_count op=%0d got=%0d exp=%0d", op, nwe, ewe); end
        total++;
        if (addr_bad || ins_bad) begin bad++; $display("FAIL fetch_stable op=%0d addr_bad=%0d ins_bad=%0d", op, addr_bad, ins_bad); end
        total++;
        if (imem_addr !== mpc) begin bad++; $display("FAIL next_pc op=%0d got=%0d exp=%0d", op, imem_addr, mpc); end
        total++;
        if (instruction !== mins) begin bad++; $display("FAIL instruction got=%h exp=%h", instruction, mins); end
        total++;
        if (retired_cnt !== mcnt) begin bad++; $display("FAIL retired_cnt got=%0d exp=%0d", retired_cnt, mcnt); end
        total++;
        if (state !== 3'(estate)) begin bad++; $display("FAIL end_state op=%0d got=%0d exp=%0d", op, state, estate); end
        total++;
        if (halted !== (estate == 5)) begin bad++; $display("FAIL halted op=%0d got=%0d", op, halted); end
        total++;
    endtask

    task automatic test_reset();
        do_reset();
        if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++;
        if (imem_addr !== 8'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", imem_addr); end
        total++;
        if (instruction !== 16'h0000) begin bad++; $display("FAIL reset_ir got=%h exp=0000", instruction); end
        total++;
        if (retired_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt); end
        total++;
        if ({imem_req, dmem_req, dmem_we, reg_we, retire, halted} !== 6'b100000) begin
            bad++; $display("FAIL reset_strobes got=%b exp=100000", {imem_req, dmem_req, dmem_we, reg_we, retire, halted});
        end
        total++;
    endtask

    task automatic test_alu();
        do_reset();
        imem[0] = 16'h3105;
        run_instr(0, 0, 0);
    endtask

    task automatic test_fetch_stall();
        imem[mpc] = 16'h2A33;
        run_instr(3, 0, 0);
    endtask

    task automatic test_load_store();
        imem[mpc] = 16'h0104;
        run_instr(0, 2, 0);
        imem[mpc] = 16'h1104;
        run_instr(0, 0, 0);
        imem[mpc] = 16'h1104;
        run_instr(1, 3, 1);
    endtask

    task automatic test_branch();
        for (int i = 0; i < 256; i++) imem[i] = 16'hE000;
        for (int b = 0; b < 2; b++) begin
            do_reset();
            while (mpc != 8'd10) run_instr(0, 0, 0);
            imem[10] = 16'hB0FC;
            run_instr(0, 0, (b == 0));
            imem[10] = 16'hE000;
        end
        imem[mpc] = 16'hC005;
        run_instr(0, 0, 1);
        while (mpc != 8'd255) run_instr(0, 0, 0);
        imem[255] = 16'h3105;
        run_instr(0, 0, 0);
        imem[255] = 16'hE000;
    endtask

    task automatic test_halt();
        bit stuck;
        do_reset();
        imem[0] = 16'h3105;
        imem[1] = 16'hF000;
        run_instr(0, 0, 0);
        run_instr(0, 0, 0);
        stuck = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            #1;
            if (imem_req !== 1'b0 || halted !== 1'b1 || state !== 3'd5 ||
                imem_addr !== mpc || retired_cnt !== mcnt || instruction !== mins ||
                retire !== 1'b0 || reg_we !== 1'b0 || dmem_req !== 1'b0) stuck = 1;
        end
        if (stuck) begin bad++; $display("FAIL halt_hold got=activity exp=frozen"); end
        total++;
        do_reset();
        if (state !== 3'd0 || halted !== 1'b0 || imem_addr !== 8'd0 || retired_cnt !== 16'd0) begin
            bad++; $display("FAIL halt_exit state=%0d halted=%0d pc=%0d cnt=%0d exp=0/0/0/0", state, halted, imem_addr, retired_cnt);
        end
        total++;
    endtask

    task automatic test_reset_in_mem();
        bit seen;
        do_reset();
        imem[0] = 16'h3105;
        imem[1] = 16'h0104;
        run_instr(0, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            imem_ack = imem_req; dmem_ack = 1'b0;
            if (dmem_req) seen = 1;
        end
        if (!seen) begin bad++; $display("FAIL mem_reach got=no_dmem_req exp=dmem_req"); end
        total++;
        rst_n = 1'b0; dmem_ack = 1'b1; imem_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; dmem_ack = 1'b0;
        if (dmem_req !== 1'b0 || state !== 3'd0 || retired_cnt !== 16'd0 || imem_addr !== 8'd0 || reg_we !== 1'b0) begin
            bad++; $display("FAIL mem_reset dmem_req=%0d state=%0d cnt=%0d pc=%0d exp=0/0/0/0", dmem_req, state, retired_cnt, imem_addr);
        end
        total++;
        mpc = '0; mcnt = '0; mins = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        do_reset();
        for (int n = 0; n < 150; n++)
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        test_alu();
        test_fetch_stall();
        test_load_store();
        test_branch();
        test_halt();
        test_reset_in_mem();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
